video_timing_gen: RTL

Generates the frame-valid / line-valid raster timing that downstream image blocks consume, plus start/end-of-frame pulses and pixel coordinates. It is the source end of the FV/LV valid-signal protocol: edge detectors in the pipeline turn its level transitions back into frame and line events. It sits in the sensor-emulation and test-pattern path, on the system clock domain.

---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/video_timing_gen_if.sv | 23 ++
 rtl/video_timing_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared state encoding and width helpers for the raster timing generator
package video_timing_pkg;

  // Raster FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    V_FRONT = 3'd1,
    ACTIVE  = 3'd2,
    H_BLK   = 3'd3,
    V_BACK  = 3'd4
  } state_t;

  // Counter width for a count of n: max(1, clog2(n))
  function automatic int cnt_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  // Largest of three blanking lengths, sizes the shared blank counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - FV/LV raster interface between the timing source and its consumers
interface video_timing_gen_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic           i_Enable;
  logic           o_Frame_valid;
  logic           o_Line_valid;
  logic           o_Sof;
  logic           o_Eof;
  logic [X_W-1:0] o_Pix_x;
  logic [Y_W-1:0] o_Pix_y;

  modport master (
    input  i_Enable,
    output o_Frame_valid, o_Line_valid, o_Sof, o_Eof, o_Pix_x, o_Pix_y
  );

  modport slave (
    output i_Enable,
    input  o_Frame_valid, o_Line_valid, o_Sof, o_Eof, o_Pix_x, o_Pix_y
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - frame/line valid raster generator with SOF/EOF pulses and pixel coordinates
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 512,
  parameter int H_BLANK      = 160,
  parameter int FV_TO_LV     = 8,
  parameter int V_BLANK      = 1000
) (
  input logic               i_Sys_clk,
  input logic               i_Rst,
  video_timing_gen_if.master vt
);

  localparam int X_W = cnt_width(IMAGE_WIDTH);
  localparam int Y_W = cnt_width(IMAGE_HEIGHT);
  localparam int B_W = cnt_width(max3(FV_TO_LV, H_BLANK, V_BLANK));

  localparam logic [X_W-1:0] X_LAST      = X_W'(IMAGE_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST      = Y_W'(IMAGE_HEIGHT - 1);
  localparam logic [B_W-1:0] FRONT_LAST  = B_W'(FV_TO_LV - 1);
  localparam logic [B_W-1:0] HBLK_LAST   = B_W'(H_BLANK - 1);
  localparam logic [B_W-1:0] VBLK_LAST   = B_W'(V_BLANK - 1);

  state_t         state;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic [B_W-1:0] b_cnt;
  logic           active;

  assign active = (state == ACTIVE);

  // Raster sequencing: one blank counter is shared by the three blanking phases
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
      b_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          b_cnt <= '0;
          if (vt.i_Enable) state <= V_FRONT;
        end
        V_FRONT: begin
          if (b_cnt == FRONT_LAST) begin
            state <= ACTIVE;
            b_cnt <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
          end else begin
            b_cnt <= b_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            b_cnt <= '0;
            if (y_cnt == Y_LAST) begin
              // last line runs straight into vertical blanking, no trailing H_BLANK
              state <= V_BACK;
            end else begin
              state <= H_BLK;
              y_cnt <= y_cnt + 1'b1;
            end
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end
        H_BLK: begin
          if (b_cnt == HBLK_LAST) begin
            state <= ACTIVE;
            b_cnt <= '0;
          end else begin
            b_cnt <= b_cnt + 1'b1;
          end
        end
        V_BACK: begin
          if (b_cnt == VBLK_LAST) begin
            b_cnt <= '0;
            y_cnt <= '0;
            // enable is only honoured here and in IDLE, so frames are never cut short
            state <= vt.i_Enable ? V_FRONT : IDLE;
          end else begin
            b_cnt <= b_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered decode of the current state so every output leaves a single flop
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      vt.o_Frame_valid <= 1'b0;
      vt.o_Line_valid  <= 1'b0;
      vt.o_Sof         <= 1'b0;
      vt.o_Eof         <= 1'b0;
      vt.o_Pix_x       <= '0;
      vt.o_Pix_y       <= '0;
    end else begin
      vt.o_Frame_valid <= (state == V_FRONT) || (state == ACTIVE) || (state == H_BLK);
      vt.o_Line_valid  <= active;
      vt.o_Sof         <= active && (x_cnt == '0) && (y_cnt == '0);
      vt.o_Eof         <= active && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
      vt.o_Pix_x       <= active ? x_cnt : '0;
      vt.o_Pix_y       <= active ? y_cnt : '0;
    end
  end

endmodule
